// File: rtl/fft_config_ctrl.sv
// FFT core config-channel sequencer: builds one config word per request, hands it over
// with valid/ready, settles, then pulses done. Optional tready timeout: CFG_TIMEOUT_EN.
module fft_config_ctrl #(
    parameter int                   NFFT_LOG2      = 10,
    parameter int                   SCALE_W        = 10,
    parameter logic [SCALE_W-1:0]   FWD_SCALE      = 10'b1010101010,
    parameter logic [SCALE_W-1:0]   INV_SCALE      = 10'b0101010101,
    parameter int                   CFG_W          = 24,
    parameter int                   SETTLE_CYCLES  = 4,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_start,
    input  logic             cfg_fwd_inv,
    output logic             cfg_done,
    output logic             cfg_busy,
    output logic [CFG_W-1:0] m_axis_config_tdata,
    output logic             m_axis_config_tvalid,
    input  logic             m_axis_config_tready,
    input  logic             event_tlast_unexpected,
    input  logic             event_tlast_missing,
    output logic [2:0]       err_flags,
    output logic [15:0]      cfg_count
);

    // Elaboration-time legality checks on the configuration
    if (NFFT_LOG2 < 3 || NFFT_LOG2 > 16) begin : g_bad_nfft
        $error("fft_config_ctrl: NFFT_LOG2 out of range");
    end
    if (SCALE_W != 2 * ((NFFT_LOG2 + 1) / 2)) begin : g_bad_scale
        $error("fft_config_ctrl: SCALE_W must be 2*ceil(NFFT_LOG2/2)");
    end
    if (CFG_W % 8 != 0 || CFG_W < 9 + SCALE_W) begin : g_bad_cfgw
        $error("fft_config_ctrl: CFG_W must be a multiple of 8 and >= 9+SCALE_W");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cnt
        $error("fft_config_ctrl: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_SETTLE, S_DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t            state;
    logic              fwd_inv_q;
    logic [7:0]        settle_cnt;
    logic [CFG_W-1:0]  cfg_word;
    logic              accept;
    logic              xfer;
    logic              timeout_hit;

    assign accept = (state == S_IDLE) && cfg_start;
    assign xfer   = m_axis_config_tvalid && m_axis_config_tready;

    always_comb begin
        cfg_word                  = '0;
        cfg_word[4:0]             = 5'(NFFT_LOG2);
        cfg_word[8]               = fwd_inv_q;
        cfg_word[8+SCALE_W:9]     = fwd_inv_q ? FWD_SCALE : INV_SCALE;
    end

`ifdef CFG_TIMEOUT_EN
    logic [15:0] wait_cnt;
    // A transfer on the final wait cycle still wins over the timeout
    assign timeout_hit = (state == S_SEND) && !xfer && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state                <= S_IDLE;
            fwd_inv_q            <= 1'b0;
            settle_cnt           <= '0;
            cfg_done             <= 1'b0;
            cfg_busy             <= 1'b0;
            m_axis_config_tdata  <= '0;
            m_axis_config_tvalid <= 1'b0;
            err_flags            <= '0;
            cfg_count            <= '0;
`ifdef CFG_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
        end else begin
            cfg_done  <= 1'b0;
            // Accepting a start clears the flags, but a same-cycle event still lands
            err_flags <= (accept ? 3'b000 : err_flags)
                       | {timeout_hit, event_tlast_missing, event_tlast_unexpected};

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        fwd_inv_q <= cfg_fwd_inv;
                        state     <= S_LOAD;
                        cfg_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    m_axis_config_tdata  <= cfg_word;
                    m_axis_config_tvalid <= 1'b1;
                    state                <= S_SEND;
`ifdef CFG_TIMEOUT_EN
                    wait_cnt             <= '0;
`endif
                end
                S_SEND: begin
                    if (xfer) begin
                        m_axis_config_tvalid <= 1'b0;
                        settle_cnt           <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            state    <= S_DONE;
                            cfg_done <= 1'b1;
                        end else begin
                            state    <= S_SETTLE;
                        end
                    end else if (timeout_hit) begin
                        m_axis_config_tvalid <= 1'b0;
                        state                <= S_DONE;
                        cfg_done             <= 1'b1;
                    end
`ifdef CFG_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= S_DONE;
                        cfg_done <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    cfg_count <= cfg_count + 16'd1;
                    state     <= S_IDLE;
                    cfg_busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_config_ctrl.sv
// Scoreboard bench for fft_config_ctrl: expected config words are queued at start,
// a negedge monitor checks transfers, settle latency, done pulses and cfg_count.
module tb_fft_config_ctrl;

    localparam int NFFT_LOG2 = 10;
    localparam int SCALE_W   = 10;
    localparam int FWD_S     = 'h2AA;
    localparam int INV_S     = 'h155;
    localparam int CFG_W     = 24;
    localparam int SETTLE    = 4;
`ifdef CFG_TIMEOUT_EN
    localparam int TO        = 16;
`else
    localparam int TO        = 1024;
`endif

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cfg_fwd_inv = 1'b0;
    logic             cfg_done;
    logic             cfg_busy;
    logic [CFG_W-1:0] tdata;
    logic             tvalid;
    logic             tready = 1'b0;
    logic             ev_unexp = 1'b0;
    logic             ev_miss = 1'b0;
    logic [2:0]       err_flags;
    logic [15:0]      cfg_count;

    fft_config_ctrl #(
        .NFFT_LOG2(NFFT_LOG2), .SCALE_W(SCALE_W),
        .FWD_SCALE(10'(FWD_S)), .INV_SCALE(10'(INV_S)),
        .CFG_W(CFG_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_fwd_inv(cfg_fwd_inv),
        .cfg_done(cfg_done), .cfg_busy(cfg_busy),
        .m_axis_config_tdata(tdata), .m_axis_config_tvalid(tvalid),
        .m_axis_config_tready(tready),
        .event_tlast_unexpected(ev_unexp), .event_tlast_missing(ev_miss),
        .err_flags(err_flags), .cfg_count(cfg_count)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: word = len + 256*dir + 512*schedule
    function automatic logic [CFG_W-1:0] exp_word(input bit fwd);
        longint v;
        v = NFFT_LOG2 + (fwd ? 256 : 0) + (fwd ? FWD_S : INV_S) * 512;
        return CFG_W'(v);
    endfunction

    logic [CFG_W-1:0] q_tdata[$];
    int  xfers = 0, dones = 0, model_count = 0;
    int  last_xfer_cyc = 0, last_done_cyc = 0, acc_cyc = 0;
    bit  xfer_pend = 0, cnt_chk = 0, prev_stall = 0;
    logic [CFG_W-1:0] prev_tdata = '0;

    // Monitor
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 0;
            cnt_chk    = 0;
        end else begin
            if (cnt_chk) begin
                chk("cfg_count", cfg_count, model_count);
                cnt_chk = 0;
            end
            if (prev_stall && tvalid) chk("tdata_stable", tdata, prev_tdata);
            if (tvalid && tready) begin
                xfers++;
                if (q_tdata.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer: got tdata %0h, expected no transfer", tdata);
                end else begin
                    chk("tdata", tdata, q_tdata.pop_front());
                end
                last_xfer_cyc = cyc;
                xfer_pend = 1;
            end
            if (cfg_done) begin
                dones++;
                last_done_cyc = cyc;
                model_count = (model_count + 1) % 65536;
                cnt_chk = 1;
                if (xfer_pend) chk("settle_latency", cyc - last_xfer_cyc, SETTLE + 1);
                xfer_pend = 0;
            end
            prev_stall = tvalid && !tready;
            prev_tdata = tdata;
        end
    end

    bit rnd_rdy = 0;
    always @(posedge aclk) if (rnd_rdy) begin #1; tready = 1'($urandom % 2); end

    task automatic do_start(input bit fwd, input bit ev);
        int n = 0;
        @(negedge aclk);
        while (cfg_busy && n < 200) begin @(negedge aclk); n++; end
        if (cfg_busy) chk("idle_wait_timeout", 1, 0);
        cfg_start = 1'b1; cfg_fwd_inv = fwd; ev_miss = ev;
        q_tdata.push_back(exp_word(fwd));
        @(posedge aclk); #1;
        cfg_start = 1'b0; ev_miss = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (dones < target && n < 2000) begin @(negedge aclk); n++; end
        if (dones < target) chk("done_wait_timeout", dones, target);
    endtask

    task automatic wait_tvalid();
        int n = 0;
        do begin @(negedge aclk); n++; end while (!tvalid && n < 50);
        if (!tvalid) chk("tvalid_wait_timeout", 0, 1);
    endtask

    initial begin
        int d0, x0, vc, n;
        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", err_flags, 0);
        chk("rst_count", cfg_count, 0);
        aresetn = 1'b1;

        // Forward config, tready high
        tready = 1'b1;
        d0 = dones;
        do_start(1, 0);
        @(negedge aclk);
        chk("busy_after_accept", cfg_busy, 1);
        wait_done(d0 + 1);
        chk("done_latency", last_done_cyc - acc_cyc, SETTLE + 2);
        @(negedge aclk);
        chk("count_after_first", cfg_count, 1);

        // Inverse config, tready low for 20 tvalid cycles
        tready = 1'b0;
        d0 = dones; x0 = xfers;
        do_start(0, 0);
        vc = 0; n = 0;
        while (vc < 20 && n < 100) begin @(negedge aclk); if (tvalid) vc++; n++; end
        chk("held_tvalid_cycles", vc, 20);
        tready = 1'b1;
        wait_done(d0 + 1);
        chk("inv_single_xfer", xfers - x0, 1);

        // Ignored start in SETTLE, fwd_inv toggled in SEND
        tready = 1'b0;
        d0 = dones; x0 = xfers;
        do_start(1, 0);
        wait_tvalid();
        repeat (4) begin cfg_fwd_inv = ~cfg_fwd_inv; @(negedge aclk); end
        tready = 1'b1;
        n = 0;
        while (!(tvalid && tready) && n < 10) begin @(negedge aclk); n++; end
        @(negedge aclk);
        cfg_start = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        wait_done(d0 + 1);
        repeat (12) @(negedge aclk);
        chk("no_second_xfer", xfers - x0, 1);
        chk("single_done", dones - d0, 1);
        chk("queue_drained", q_tdata.size(), 0);

        // Sticky error flags
        ev_miss = 1'b1;
        @(posedge aclk); #1; ev_miss = 1'b0;
        @(negedge aclk);
        chk("err_after_pulse", err_flags, 3'b010);
        d0 = dones;
        do_start(0, 0);
        @(negedge aclk);
        chk("err_cleared_on_accept", err_flags, 3'b000);
        wait_done(d0 + 1);
        do_start(1, 1);
        @(negedge aclk);
        chk("err_pulse_on_accept", err_flags, 3'b010);
        ev_unexp = 1'b1;
        @(posedge aclk); #1; ev_unexp = 1'b0;
        @(negedge aclk);
        chk("err_accumulate", err_flags, 3'b011);
        wait_done(d0 + 2);

        // Reset in the middle of SEND
        tready = 1'b0;
        do_start(1, 0);
        wait_tvalid();
        d0 = dones;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        q_tdata.delete();
        xfer_pend = 0;
        model_count = 0;
        @(negedge aclk);
        chk("rst_mid_tvalid", tvalid, 0);
        chk("rst_mid_busy", cfg_busy, 0);
        chk("rst_mid_count", cfg_count, 0);
        repeat (6) @(negedge aclk);
        chk("rst_mid_no_done", dones - d0, 0);
        tready = 1'b1;
        do_start(0, 0);
        wait_done(d0 + 1);

`ifdef CFG_TIMEOUT_EN
        // Timeout: tvalid drops after TO cycles, done still pulses
        tready = 1'b0;
        d0 = dones;
        do_start(1, 0);
        vc = 0; n = 0;
        do begin @(negedge aclk); if (tvalid) vc++; n++; end while ((tvalid || vc == 0) && n < 100);
        chk("timeout_tvalid_cycles", vc, TO);
        wait_done(d0 + 1);
        @(negedge aclk);
        chk("timeout_err", err_flags, 3'b100);
        chk("timeout_one_done", dones - d0, 1);
        q_tdata.delete();
`else
        // Without the timeout build SEND waits indefinitely
        tready = 1'b0;
        d0 = dones;
        do_start(1, 0);
        repeat (100) @(negedge aclk);
        chk("no_timeout_tvalid", tvalid, 1);
        chk("no_timeout_err", err_flags[2], 0);
        tready = 1'b1;
        wait_done(d0 + 1);
`endif

        // Randomised configs with random tready back-pressure
        @(negedge aclk);
        rnd_rdy = 1;
        for (int i = 0; i < 30; i++) begin
            d0 = dones;
            repeat ($urandom_range(0, 3)) @(negedge aclk);
            do_start(1'($urandom % 2), 0);
            wait_done(d0 + 1);
        end
        @(negedge aclk);
        rnd_rdy = 0;
        repeat (6) @(negedge aclk);
        chk("rand_queue_drained", q_tdata.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
